piece_dropper: RTL

Writer side of the Connect-4 board RAM: accepts a column drop request for a player, scans the column bottom-up through the shared 2-bit board RAM to find the lowest empty cell, writes the player's code there, then holds the win checker's start level until it reports completion. It owns the RAM port while the win checker is not running, and hands the port to the checker only during the CHECK phase.

---
 rtl/connect4_pkg.sv | 32 +++
 rtl/piece_dropper_if.sv | 32 +++
 rtl/ram_read_wait.sv | 26 ++
 rtl/piece_dropper.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect-4 board constants, cell codes and the dropper state encoding.
// BOARD_CLEAR_EN adds the CLEAR state used by the board-clear feature.
package connect4_pkg;

  localparam int BOARD_BASE = 7;
  localparam int BOARD_COLS = 7;
  localparam int BOARD_ROWS = 6;
  localparam int BOARD_LAST = 48;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_FAIL
`ifdef BOARD_CLEAR_EN
    , ST_CLEAR
`endif
  } drop_state_t;

  // Address of the bottom-row cell of a column; scanning moves up from here.
  function automatic logic [5:0] bottom_addr(input int base, input int cols,
                                             input int rows, input logic [2:0] col);
    return 6'(base + (rows - 1) * cols) + {3'b000, col};
  endfunction

endpackage

// File: rtl/piece_dropper_if.sv
// Drop request, win-checker handshake and board RAM port of the piece dropper.
// The dropper is the slave; the game controller / RAM side is the master.
interface piece_dropper_if;
  logic       drop_req;
  logic [2:0] column;
  logic [1:0] player;
  logic       game_over;
  logic [1:0] q;
  logic [5:0] ram_addr;
  logic [1:0] ram_data;
  logic       ram_wren;
  logic       check_start;
  logic       check_complete;
  logic       busy;
  logic       drop_done;
  logic       drop_fail;
  logic [5:0] placed_addr;
  logic       clear_req;
  logic       clear_done;

  modport slave (
    input  drop_req, column, player, game_over, q, check_complete, clear_req,
    output ram_addr, ram_data, ram_wren, check_start, busy, drop_done,
           drop_fail, placed_addr, clear_done
  );

  modport master (
    output drop_req, column, player, game_over, q, check_complete, clear_req,
    input  ram_addr, ram_data, ram_wren, check_start, busy, drop_done,
           drop_fail, placed_addr, clear_done
  );
endinterface

// File: rtl/ram_read_wait.sv
// Load/count-down timer: done is high in the RD_LAT-th cycle after a load,
// which is the cycle in which the RAM read data is valid.
module ram_read_wait #(
  parameter int RD_LAT = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  output logic done
);

  logic [2:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= 3'd0;
    end else if (load) begin
      cnt <= 3'(RD_LAT);
    end else if (cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign done = (cnt == 3'd1);

endmodule

// File: rtl/piece_dropper.sv
// Connect-4 board writer: scans a column bottom-up for the lowest empty cell,
// writes the player's code, then runs the win checker. Optional BOARD_CLEAR_EN.
module piece_dropper
  import connect4_pkg::*;
#(
  parameter int RD_LAT    = 3,
  parameter int BASE_ADDR = BOARD_BASE,
  parameter int COLS      = BOARD_COLS,
  parameter int ROWS      = BOARD_ROWS
) (
  input  logic           clk,
  input  logic           resetn,
  piece_dropper_if.slave bus
);

  drop_state_t state;
  logic [5:0]  addr;
  logic [2:0]  row;
  logic [1:0]  player_q;
  logic [5:0]  ram_addr_r;
  logic [1:0]  ram_data_r;
  logic        ram_wren_r;
  logic        check_start_r;
  logic        busy_r;
  logic        drop_done_r;
  logic        drop_fail_r;
  logic [5:0]  placed_addr_r;
  logic        clear_go;
  logic        request_ok;
  logic        rd_done;
  logic        rd_load;
  logic        cell_taken;

  assign request_ok = (bus.column <= 3'(COLS - 1)) && !bus.game_over &&
                      ((bus.player == CELL_P1) || (bus.player == CELL_P2));
  assign cell_taken = (bus.q != CELL_EMPTY);

  // The timer is (re)loaded on acceptance and whenever the scan moves one row up.
  assign rd_load = ((state == ST_IDLE) && bus.drop_req && request_ok && !clear_go) ||
                   ((state == ST_READ) && rd_done && cell_taken && (row != 3'd0));

  ram_read_wait #(.RD_LAT(RD_LAT)) u_wait (
    .clk    (clk),
    .resetn (resetn),
    .load   (rd_load),
    .done   (rd_done)
  );

`ifdef BOARD_CLEAR_EN
  logic clear_done_r;
  assign clear_go       = bus.clear_req;
  assign bus.clear_done = clear_done_r;
`else
  logic unused_clear_req;
  assign clear_go         = 1'b0;
  assign unused_clear_req = bus.clear_req;
  assign bus.clear_done   = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      addr          <= 6'd0;
      row           <= 3'd0;
      player_q      <= CELL_EMPTY;
      ram_addr_r    <= 6'd0;
      ram_data_r    <= CELL_EMPTY;
      ram_wren_r    <= 1'b0;
      check_start_r <= 1'b0;
      busy_r        <= 1'b0;
      drop_done_r   <= 1'b0;
      drop_fail_r   <= 1'b0;
      placed_addr_r <= 6'd0;
`ifdef BOARD_CLEAR_EN
      clear_done_r  <= 1'b0;
`endif
    end else begin
      drop_done_r <= 1'b0;
      drop_fail_r <= 1'b0;
`ifdef BOARD_CLEAR_EN
      clear_done_r <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
`ifdef BOARD_CLEAR_EN
          if (clear_go) begin
            state      <= ST_CLEAR;
            busy_r     <= 1'b1;
            ram_addr_r <= 6'd0;
            ram_data_r <= CELL_EMPTY;
            ram_wren_r <= 1'b1;
          end else
`endif
          if (bus.drop_req) begin
            busy_r <= 1'b1;
            if (!request_ok) begin
              state       <= ST_FAIL;
              drop_fail_r <= 1'b1;
            end else begin
              state      <= ST_READ;
              player_q   <= bus.player;
              row        <= 3'(ROWS - 1);
              addr       <= bottom_addr(BASE_ADDR, COLS, ROWS, bus.column);
              ram_addr_r <= bottom_addr(BASE_ADDR, COLS, ROWS, bus.column);
            end
          end
        end
        ST_READ: begin
          if (rd_done) begin
            if (!cell_taken) begin
              state      <= ST_WRITE;
              ram_wren_r <= 1'b1;
              ram_data_r <= player_q;
            end else if (row == 3'd0) begin
              state       <= ST_FAIL;
              drop_fail_r <= 1'b1;
              ram_addr_r  <= 6'd0;
            end else begin
              row        <= row - 3'd1;
              addr       <= addr - 6'(COLS);
              ram_addr_r <= addr - 6'(COLS);
            end
          end
        end
        // Port is released here so the win checker can drive the RAM.
        ST_WRITE: begin
          state         <= ST_CHECK;
          ram_wren_r    <= 1'b0;
          ram_data_r    <= CELL_EMPTY;
          ram_addr_r    <= 6'd0;
          placed_addr_r <= addr;
          check_start_r <= 1'b1;
        end
        ST_CHECK: begin
          if (bus.check_complete) begin
            state         <= ST_DONE;
            check_start_r <= 1'b0;
            drop_done_r   <= 1'b1;
          end
        end
        ST_DONE, ST_FAIL: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
`ifdef BOARD_CLEAR_EN
        ST_CLEAR: begin
          if (ram_addr_r == 6'(BOARD_LAST)) begin
            state        <= ST_IDLE;
            busy_r       <= 1'b0;
            ram_wren_r   <= 1'b0;
            ram_addr_r   <= 6'd0;
            clear_done_r <= 1'b1;
          end else begin
            ram_addr_r <= ram_addr_r + 6'd1;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ram_addr    = ram_addr_r;
  assign bus.ram_data    = ram_data_r;
  assign bus.ram_wren    = ram_wren_r;
  assign bus.check_start = check_start_r;
  assign bus.busy        = busy_r;
  assign bus.drop_done   = drop_done_r;
  assign bus.drop_fail   = drop_fail_r;
  assign bus.placed_addr = placed_addr_r;

endmodule
